qualificador_sol: RTL and testbench
===================================

# qualificador_sol

Upstream conditioning stage for the pool-pump power selector: turns a raw multi-bit light-level reading into a clean, debounced `sol` flag. Adds 2-stage input synchronization, hysteresis (separate on/off thresholds) and persistence qualification, so the pump controller never chatters between solar panel and grid. Sits between the board switches/sensor (`SWI[7:2]`) and the controller's `sol` input; state and counter are exported for LED/7-segment debug.

## Interface
- `NBITS_NIVEL`, 6: width of the light-level input.
- `LIMIAR_LIGA`, 40: level at or above which a sample counts as "sun". Must be > `LIMIAR_DESLIGA`.
- `LIMIAR_DESLIGA`, 24: level strictly below which a sample counts as "dark".
- `CICLOS_CONFIRMA`, 4: consecutive qualifying samples needed to change `sol`. Legal range 2..15.

- `clk_2`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `nivel`  in  `NBITS_NIVEL`  raw light level, asynchronous to `clk_2`, unsigned.
- `forca`  in  1  manual sun override; used only with `FORCA_SOL_EN`.
- `sol`  out  1  qualified sun flag, registered; feeds pump controller.
- `mudou`  out  1  one-cycle pulse on any `sol` change.
- `estado`  out  2  current FSM state code.
- `contador`  out  4  confirmation counter.

## Operation
- Synchronizer: two registers `nivel_s1` <- `nivel`, `nivel_s` <- `nivel_s1`. FSM uses only `nivel_s`.
- Unsigned compare: `alto` = `nivel_s >= LIMIAR_LIGA`; `baixo` = `nivel_s < LIMIAR_DESLIGA`. Values in `[LIMIAR_DESLIGA, LIMIAR_LIGA)` are the hysteresis band: neither.
- States (code): ESCURO=0, CONF_SOL=1, SOL=2, CONF_ESCURO=3.
- ESCURO: `alto` -> CONF_SOL, `contador`=1; else stay, `contador`=0.
- CONF_SOL: not `alto` -> ESCURO, `contador`=0; `alto` and `contador`==`CICLOS_CONFIRMA`-1 -> SOL, `contador`=0, `sol`<=1; else `contador`+1.
- SOL: `baixo` -> CONF_ESCURO, `contador`=1; else stay, `contador`=0.
- CONF_ESCURO: not `baixo` -> SOL, `contador`=0; `baixo` and `contador`==`CICLOS_CONFIRMA`-1 -> ESCURO, `contador`=0, `sol`<=0; else `contador`+1.
- `sol` is 1 in SOL and CONF_ESCURO, 0 in ESCURO and CONF_SOL; always a register, never decoded combinationally.
- `mudou` <= 1 on the edge where `sol` toggles, else 0.
- Band samples abort confirmation in either CONF state; a rising sequence interrupted by one band sample restarts from 1.
- `contador` never exceeds `CICLOS_CONFIRMA`-1; no wrap.

## Timing
- Reset (sync, on `clk_2` edge with `reset`=1): `nivel_s1`=0, `nivel_s`=0, state ESCURO, `contador`=0, `sol`=0, `mudou`=0. `reset` overrides everything incl. override; reset mid-confirmation discards progress.
- Latency: `nivel` stable from before edge 1 -> `nivel_s` valid after edge 2 -> first FSM sample edge 3 -> `sol` changes after edge `CICLOS_CONFIRMA`+2 (edge 6 at default), `mudou` high for the cycle after that same edge.
- Minimum `sol` pulse width: `CICLOS_CONFIRMA` cycles (opposite condition needs that many samples).
- One state transition per edge; no combinational path from `nivel` to any output.

## Configuration
- `FORCA_SOL_EN` defined: `forca` registered once (`forca_r`); while `forca_r`=1 the FSM enters/holds SOL with `contador`=0 and `sol`=1 regardless of `nivel_s` (`mudou` pulses if `sol` was 0). On `forca_r` fall, normal evaluation resumes from SOL. `reset` still wins.
- Not defined: `forca` ignored, no `forca_r` register; behaviour exactly as in Operation.

## Test plan
- Reset then `nivel`=63 held -> `sol`=0 through edge 5, `sol`=1 after edge 6, `mudou`=1 for exactly one cycle, `estado` sequence 0,1,1,1,2.
- From SOL, `nivel`=30 (band) held 20 cycles -> `sol` stays 1, `estado`=2, `contador`=0.
- From ESCURO, `nivel`=50 for 2 samples, 30 for 1, 50 for 4 -> `contador` 1,2,0,1,2,3, `sol` rises only after the final 4-sample run.
- From SOL, `nivel`=10 for 4 samples -> `sol` falls at 4th sample, `estado` 3,3,3,0; `reset` asserted at 3rd sample instead -> `sol`=0, `estado`=0, `contador`=0 next cycle.
- With `FORCA_SOL_EN`, `nivel`=0, `forca`=1 -> `sol`=1 two edges later; release `forca` -> `sol`=0 after `CICLOS_CONFIRMA` further samples.

Source files
------------

// File: rtl/qualificador_sol.sv
// qualificador_sol
//   Conditioning stage between the raw light-level sensor/switches and the
//   pool-pump controller. It produces a clean, debounced "sun" flag:
//     - 2-stage synchronizer on the asynchronous level input
//     - hysteresis: separate "on" (LIMIAR_LIGA) and "off" (LIMIAR_DESLIGA)
//       thresholds, with a neutral band between them
//     - persistence: CICLOS_CONFIRMA consecutive qualifying samples are
//       needed before the flag changes
//
//   Optional feature (compile-time macro FORCA_SOL_EN):
//     defined   -> 'forca' is registered once and, while high, forces the
//                  FSM into SOL (sol=1, contador=0). Reset still wins.
//     undefined -> 'forca' is ignored and no register is built for it.
//
// Ports
//   clk_2     in   1            system clock, rising edge
//   reset     in   1            synchronous, active-high reset
//   nivel     in   NBITS_NIVEL  raw light level, asynchronous, unsigned
//   forca     in   1            manual sun override (FORCA_SOL_EN only)
//   sol       out  1            qualified sun flag, registered
//   mudou     out  1            one-cycle pulse after each change of sol
//   estado    out  2            FSM state code (debug)
//   contador  out  4            confirmation counter (debug)
//
// Handshake: none. The block is a free-running filter; every output is a
// register updated on each rising edge of clk_2, with no combinational
// path from any input to any output.
module qualificador_sol #(
  parameter int NBITS_NIVEL     = 6,
  parameter int LIMIAR_LIGA     = 40,
  parameter int LIMIAR_DESLIGA  = 24,
  parameter int CICLOS_CONFIRMA = 4
) (
  input  logic                   clk_2,
  input  logic                   reset,
  input  logic [NBITS_NIVEL-1:0] nivel,
  input  logic                   forca,
  output logic                   sol,
  output logic                   mudou,
  output logic [1:0]             estado,
  output logic [3:0]             contador
);

  typedef enum logic [1:0] {
    ESCURO      = 2'd0,
    CONF_SOL    = 2'd1,
    SOL         = 2'd2,
    CONF_ESCURO = 2'd3
  } estado_t;

  localparam logic [NBITS_NIVEL-1:0] LIGA    = NBITS_NIVEL'(LIMIAR_LIGA);
  localparam logic [NBITS_NIVEL-1:0] DESLIGA = NBITS_NIVEL'(LIMIAR_DESLIGA);
  // Last count value before a confirmation completes; the counter never
  // goes beyond this.
  localparam logic [3:0]             CNT_MAX = 4'(CICLOS_CONFIRMA - 1);

  logic [NBITS_NIVEL-1:0] r_nivel_s1;
  logic [NBITS_NIVEL-1:0] r_nivel_s;
  estado_t                r_estado;
  logic [3:0]             r_contador;
  logic                   r_sol;
  logic                   r_mudou;

  estado_t                w_estado_nxt;
  logic [3:0]             w_contador_nxt;
  logic                   w_sol_nxt;
  logic                   w_alto;
  logic                   w_baixo;

`ifdef FORCA_SOL_EN
  logic r_forca;

  always_ff @(posedge clk_2) begin
    if (reset) r_forca <= 1'b0;
    else       r_forca <= forca;
  end
`else
  // Override not built: keep the port connected but functionally inert.
  logic w_forca_unused;
  assign w_forca_unused = forca;
`endif

  // Only the second synchronizer stage is ever looked at by the FSM.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_nivel_s1 <= '0;
      r_nivel_s  <= '0;
    end else begin
      r_nivel_s1 <= nivel;
      r_nivel_s  <= r_nivel_s1;
    end
  end

  // Values in [DESLIGA, LIGA) are the hysteresis band: neither flag set.
  assign w_alto  = (r_nivel_s >= LIGA);
  assign w_baixo = (r_nivel_s <  DESLIGA);

  always_comb begin
    w_estado_nxt   = r_estado;
    w_contador_nxt = r_contador;
    case (r_estado)
      ESCURO: begin
        if (w_alto) begin
          w_estado_nxt   = CONF_SOL;
          w_contador_nxt = 4'd1;
        end else begin
          w_contador_nxt = 4'd0;
        end
      end
      CONF_SOL: begin
        // Any non-"sun" sample (band included) restarts the qualification.
        if (!w_alto) begin
          w_estado_nxt   = ESCURO;
          w_contador_nxt = 4'd0;
        end else if (r_contador == CNT_MAX) begin
          w_estado_nxt   = SOL;
          w_contador_nxt = 4'd0;
        end else begin
          w_contador_nxt = r_contador + 4'd1;
        end
      end
      SOL: begin
        if (w_baixo) begin
          w_estado_nxt   = CONF_ESCURO;
          w_contador_nxt = 4'd1;
        end else begin
          w_contador_nxt = 4'd0;
        end
      end
      CONF_ESCURO: begin
        if (!w_baixo) begin
          w_estado_nxt   = SOL;
          w_contador_nxt = 4'd0;
        end else if (r_contador == CNT_MAX) begin
          w_estado_nxt   = ESCURO;
          w_contador_nxt = 4'd0;
        end else begin
          w_contador_nxt = r_contador + 4'd1;
        end
      end
      default: begin
        w_estado_nxt   = ESCURO;
        w_contador_nxt = 4'd0;
      end
    endcase
`ifdef FORCA_SOL_EN
    if (r_forca) begin
      w_estado_nxt   = SOL;
      w_contador_nxt = 4'd0;
    end
`endif
    // The flag belongs to the "sun side" states; it is registered below so
    // the controller never sees a decoded glitch.
    w_sol_nxt = (w_estado_nxt == SOL) || (w_estado_nxt == CONF_ESCURO);
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_estado   <= ESCURO;
      r_contador <= 4'd0;
      r_sol      <= 1'b0;
      r_mudou    <= 1'b0;
    end else begin
      r_estado   <= w_estado_nxt;
      r_contador <= w_contador_nxt;
      r_sol      <= w_sol_nxt;
      r_mudou    <= w_sol_nxt ^ r_sol;
    end
  end

  assign sol      = r_sol;
  assign mudou    = r_mudou;
  assign estado   = r_estado;
  assign contador = r_contador;

endmodule

// File: tb/tb_qualificador_sol.sv
module tb_qualificador_sol;

  localparam int NB   = 6;
  localparam int LIGA = 40;
  localparam int DESL = 24;
  localparam int NCF  = 4;

  // ---------------- clock / reset ----------------
  logic          clk_2 = 1'b0;
  logic          reset;
  logic [NB-1:0] nivel;
  logic          forca;
  logic          sol;
  logic          mudou;
  logic [1:0]    estado;
  logic [3:0]    contador;

  always #5 clk_2 = ~clk_2;

  qualificador_sol #(
    .NBITS_NIVEL    (NB),
    .LIMIAR_LIGA    (LIGA),
    .LIMIAR_DESLIGA (DESL),
    .CICLOS_CONFIRMA(NCF)
  ) dut (
    .clk_2   (clk_2),
    .reset   (reset),
    .nivel   (nivel),
    .forca   (forca),
    .sol     (sol),
    .mudou   (mudou),
    .estado  (estado),
    .contador(contador)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Thinks in terms of "input seen two edges late" and "length of the
  // current run of samples that argue against the present flag".
  int m_hist[2];     // [0] = newest raw sample, [1] = sample the filter sees next
  int m_forca_d;     // override as seen one edge late
  int m_sol;
  int m_run;
  int m_mud;
  int m_valid = 0;

  always @(posedge clk_2) begin
    int seen;
    int frc;
    int prev;
    if (reset) begin
      m_hist[0] = 0; m_hist[1] = 0; m_forca_d = 0;
      m_sol = 0; m_run = 0; m_mud = 0; m_valid = 1;
    end else if (m_valid != 0) begin
      seen = m_hist[1];
      frc  = m_forca_d;
      m_hist[1] = m_hist[0];
      m_hist[0] = int'(nivel);
`ifdef FORCA_SOL_EN
      m_forca_d = int'(forca);
`else
      m_forca_d = 0;
`endif
      prev = m_sol;
      if (frc != 0) begin
        m_sol = 1; m_run = 0;
      end else begin
        // A sample counts toward flipping only if it is on the far side of
        // the threshold that opposes the present flag.
        if ((m_sol == 0 && seen >= LIGA) || (m_sol == 1 && seen < DESL)) m_run++;
        else m_run = 0;
        if (m_run == NCF) begin
          m_sol = 1 - m_sol; m_run = 0;
        end
      end
      m_mud = (m_sol != prev) ? 1 : 0;
    end
    #1;
    if (m_valid != 0) begin
      check("model_sol", int'(sol), m_sol);
      check("model_mudou", int'(mudou), m_mud);
      check("model_contador", int'(contador), m_run);
      check("model_estado", int'(estado), 2 * m_sol + ((m_run != 0) ? 1 : 0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk_2);
  endtask

  task automatic hold(input int lvl, input int n);
    nivel = NB'(lvl);
    step(n);
  endtask

  // ---------------- directed stimulus ----------------
  int exp_cnt[7];
  int exp_sol[7];
  int seq[7];

  initial begin
    reset = 1'b1; nivel = '0; forca = 1'b0;
    step(2);
    check("reset_sol", int'(sol), 0);
    check("reset_estado", int'(estado), 0);
    check("reset_contador", int'(contador), 0);
    check("reset_mudou", int'(mudou), 0);

    // Rise with full-scale light: flag after edge 6
    reset = 1'b0; nivel = 6'd63;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      check("rise_sol", int'(sol), (k == 6) ? 1 : 0);
      check("rise_mudou", int'(mudou), (k == 6) ? 1 : 0);
      if (k >= 2) check("rise_estado", int'(estado), (k == 6) ? 2 : ((k == 2) ? 0 : 1));
    end
    step(1);
    check("rise_mudou_one_cycle", int'(mudou), 0);

    // Band level does not drop the flag
    hold(30, 20);
    check("band_sol", int'(sol), 1);
    check("band_estado", int'(estado), 2);
    check("band_contador", int'(contador), 0);

    // Fall with dark level: 3,3,3,0
    nivel = 6'd10;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      if (k >= 3) check("fall_estado", int'(estado), (k == 6) ? 0 : 3);
      check("fall_sol", int'(sol), (k == 6) ? 0 : 1);
    end

    // Interrupted rise: 50,50,30,50,50,50,50
    seq[0] = 50; seq[1] = 50; seq[2] = 30; seq[3] = 50; seq[4] = 50; seq[5] = 50; seq[6] = 50;
    exp_cnt[0] = 1; exp_cnt[1] = 2; exp_cnt[2] = 0; exp_cnt[3] = 1;
    exp_cnt[4] = 2; exp_cnt[5] = 3; exp_cnt[6] = 0;
    for (int i = 0; i < 7; i++) exp_sol[i] = (i == 6) ? 1 : 0;
    for (int j = 1; j <= 9; j++) begin
      nivel = (j <= 7) ? NB'(seq[j-1]) : 6'd50;
      step(1);
      if (j >= 3) begin
        check("restart_contador", int'(contador), exp_cnt[j-3]);
        check("restart_sol", int'(sol), exp_sol[j-3]);
      end
    end

    // Reset in the middle of a fall confirmation discards progress
    nivel = 6'd10;
    step(4);
    check("midfall_estado", int'(estado), 3);
    reset = 1'b1;
    step(1);
    check("midreset_sol", int'(sol), 0);
    check("midreset_estado", int'(estado), 0);
    check("midreset_contador", int'(contador), 0);
    reset = 1'b0;

    // Threshold boundaries: 39 is band, 40 is sun, 24 is band, 23 is dark
    hold(39, 10);
    check("edge39_sol", int'(sol), 0);
    hold(40, 10);
    check("edge40_sol", int'(sol), 1);
    hold(24, 10);
    check("edge24_sol", int'(sol), 1);
    hold(23, 10);
    check("edge23_sol", int'(sol), 0);

`ifdef FORCA_SOL_EN
    nivel = 6'd0;
    step(4);
    forca = 1'b1;
    step(1);
    check("force_sol_edge1", int'(sol), 0);
    step(1);
    check("force_sol_edge2", int'(sol), 1);
    check("force_mudou", int'(mudou), 1);
    step(5);
    check("force_hold_sol", int'(sol), 1);
    check("force_hold_contador", int'(contador), 0);
    forca = 1'b0;
    step(4);
    check("release_sol_still", int'(sol), 1);
    step(1);
    check("release_sol_fall", int'(sol), 0);
`endif

    step(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
